// File: rtl/ej2_defs.sv
// Shared definitions for the ej2 serializer and the ej2a detector bench.
package ej2_defs;
   localparam int DEF_WIDTH = 8;

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_SHIFT = 1'b1
   } state_t;
endpackage

// File: rtl/ej2_serializer.sv
// Parallel-to-serial stage feeding the ej2a detector: valid/ready word load,
// one bit per clock on w, back-to-back words stream with no idle gap.
module ej2_serializer
   import ej2_defs::*;
#(
   parameter int   WIDTH     = DEF_WIDTH,
   parameter bit   MSB_FIRST = 1'b1,
   parameter logic IDLE_BIT  = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] data_in,
   input  logic             load,
   output logic             ready,
   output logic             w,
   output logic             w_valid,
   output logic             done
);
   localparam int             CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

   state_t           r_state, w_nxt_state;
   logic [WIDTH-1:0] r_sr, w_nxt_sr;
   logic [CW-1:0]    r_cnt, w_nxt_cnt;
   logic             r_w, r_w_valid, r_done;
   logic             w_accept, w_last, w_nxt_bit;

   // r_done is high exactly in last-bit cycles, so ready never sees load.
   assign w_last   = (r_cnt == LAST);
   assign ready    = (r_state == S_IDLE) || r_done;
   assign w_accept = load && ready;

   assign w       = r_w;
   assign w_valid = r_w_valid;
   assign done    = r_done;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_sr      <= '0;
         r_cnt     <= '0;
         r_w       <= IDLE_BIT;
         r_w_valid <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_state   <= w_nxt_state;
         r_sr      <= w_nxt_sr;
         r_cnt     <= w_nxt_cnt;
         r_w       <= (w_nxt_state == S_SHIFT) ? w_nxt_bit : IDLE_BIT;
         r_w_valid <= (w_nxt_state == S_SHIFT);
         r_done    <= (w_nxt_state == S_SHIFT) && (w_nxt_cnt == LAST);
      end
   end

   always_comb begin
      w_nxt_state = r_state;
      w_nxt_sr    = r_sr;
      w_nxt_cnt   = r_cnt;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_nxt_sr    = data_in;
               w_nxt_cnt   = '0;
               w_nxt_state = S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (w_last && w_accept) begin
               w_nxt_sr  = data_in;
               w_nxt_cnt = '0;
            end else if (w_last) begin
               w_nxt_state = S_IDLE;
            end else begin
               w_nxt_sr  = MSB_FIRST ? (r_sr << 1) : (r_sr >> 1);
               w_nxt_cnt = r_cnt + CW'(1);
            end
         end
         default: w_nxt_state = S_IDLE;
      endcase
      // Output bit is registered, so look ahead at the next shift-register head.
      w_nxt_bit = MSB_FIRST ? w_nxt_sr[WIDTH-1] : w_nxt_sr[0];
   end
endmodule

// File: tb/tb_ej2_serializer.sv
// Directed bench for ej2_serializer: MSB-first, LSB-first and WIDTH=1 instances.
module tb_ej2_serializer;
   import ej2_defs::*;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] d0, d1;
   logic [0:0] d2;
   logic       ld0, ld1, ld2;
   logic       rdy0, w0, v0, dn0;
   logic       rdy1, w1, v1, dn1;
   logic       rdy2, w2, v2, dn2;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   ej2_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_msb (
      .clk(clk), .reset(reset), .data_in(d0), .load(ld0),
      .ready(rdy0), .w(w0), .w_valid(v0), .done(dn0));

   ej2_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) u_lsb (
      .clk(clk), .reset(reset), .data_in(d1), .load(ld1),
      .ready(rdy1), .w(w1), .w_valid(v1), .done(dn1));

   ej2_serializer #(.WIDTH(1), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_w1 (
      .clk(clk), .reset(reset), .data_in(d2), .load(ld2),
      .ready(rdy2), .w(w2), .w_valid(v2), .done(dn2));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Checks one cycle of u_msb against an expected bit; last flags done/ready.
   task automatic chk_msb(input string tag, input logic bit_exp, input logic last);
      chk({tag, ".w"}, w0, bit_exp);
      chk({tag, ".v"}, v0, 1'b1);
      chk({tag, ".done"}, dn0, last);
      chk({tag, ".rdy"}, rdy0, last);
   endtask

   task automatic chk_idle0(input string tag);
      chk({tag, ".idle_w"}, w0, 1'b0);
      chk({tag, ".idle_v"}, v0, 1'b0);
      chk({tag, ".idle_done"}, dn0, 1'b0);
      chk({tag, ".idle_rdy"}, rdy0, 1'b1);
   endtask

   initial begin
      logic [7:0]  b2     = 8'hB2;
      logic [7:0]  lsbexp = 8'b1011_0010; // 0,1,0,0,1,1,0,1 when read from bit 0
      logic [15:0] b2b    = 16'hB20F;
      logic [7:0]  x81    = 8'h81;
      logic [2:0]  w1seq  = 3'b101;

      reset = 1'b1;
      d0 = '0; d1 = '0; d2 = '0;
      ld0 = 1'b0; ld1 = 1'b0; ld2 = 1'b0;
      #12;
      chk_idle0("rst");
      chk("rst.lsb_rdy", rdy1, 1'b1);
      chk("rst.w1_v", v2, 1'b0);
      step();
      reset = 1'b0;
      step();

      // Single word
      d0 = b2; ld0 = 1'b1;
      step();
      ld0 = 1'b0; d0 = 8'h00;
      for (int i = 0; i < 8; i++) begin
         chk_msb($sformatf("single[%0d]", i), b2[7-i], i == 7);
         step();
      end
      chk_idle0("single.after");
      step();

      // Back-to-back: second word offered in the last-bit cycle
      d0 = 8'hB2; ld0 = 1'b1;
      step();
      ld0 = 1'b0;
      for (int i = 0; i < 16; i++) begin
         chk_msb($sformatf("b2b[%0d]", i), b2b[15-i], (i == 7) || (i == 15));
         if (i == 7) begin d0 = 8'h0F; ld0 = 1'b1; end
         else        begin ld0 = 1'b0; d0 = 8'hAA; end
         step();
      end
      chk_idle0("b2b.after");

      // Loads while not ready are ignored
      d0 = b2; ld0 = 1'b1;
      step();
      ld0 = 1'b0;
      for (int i = 0; i < 8; i++) begin
         chk_msb($sformatf("ign[%0d]", i), b2[7-i], i == 7);
         if (i >= 0 && i <= 4) begin ld0 = 1'b1; d0 = 8'hFF; end
         else                  begin ld0 = 1'b0; d0 = 8'h00; end
         step();
      end
      chk_idle0("ign.after");

      // Reset during bit 3
      d0 = b2; ld0 = 1'b1;
      step();
      ld0 = 1'b0;
      chk_msb("rstmid[0]", 1'b1, 1'b0);
      step();
      chk_msb("rstmid[1]", 1'b0, 1'b0);
      step();
      chk_msb("rstmid[2]", 1'b1, 1'b0);
      #2 reset = 1'b1;
      #1;
      chk_idle0("rstmid.async");
      step();
      reset = 1'b0;
      step();
      chk_idle0("rstmid.post");
      d0 = x81; ld0 = 1'b1;
      step();
      ld0 = 1'b0;
      for (int i = 0; i < 8; i++) begin
         chk_msb($sformatf("x81[%0d]", i), x81[7-i], i == 7);
         step();
      end
      chk_idle0("x81.after");

      // LSB-first instance
      d1 = 8'hB2; ld1 = 1'b1;
      step();
      ld1 = 1'b0;
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("lsb[%0d].w", i), w1, lsbexp[i]);
         chk($sformatf("lsb[%0d].v", i), v1, 1'b1);
         chk($sformatf("lsb[%0d].done", i), dn1, i == 7);
         step();
      end
      chk("lsb.after_v", v1, 1'b0);

      // WIDTH=1 with load on every cycle
      ld2 = 1'b1;
      for (int i = 0; i < 3; i++) begin
         d2 = w1seq[2-i];
         step();
         chk($sformatf("w1[%0d].w", i), w2, w1seq[2-i]);
         chk($sformatf("w1[%0d].v", i), v2, 1'b1);
         chk($sformatf("w1[%0d].done", i), dn2, 1'b1);
         chk($sformatf("w1[%0d].rdy", i), rdy2, 1'b1);
      end
      ld2 = 1'b0;
      step();
      chk("w1.after_v", v2, 1'b0);
      chk("w1.after_done", dn2, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
